// File: rtl/irtcv_host.sv
// Fabric-side initiator for the IR transceiver: turns one valid/ready command into
// control-bus register cycles or exe/learn sequencing and returns one response.
module irtcv_host #(
    parameter int              AW     = 4,
    parameter int              DW     = 8,
    parameter logic [AW-1:0]   DR_ADR = 'h3,
    parameter int              TO_W   = 16,
    parameter logic [TO_W-1:0] TO_MAX = 16'hFFFF
) (
    input  logic          irtcv_clk,
    input  logic          irtcv_rst_async_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_wdat,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          irtcv_cs,
    output logic          irtcv_we,
    output logic          irtcv_den,
    output logic [AW-1:0] irtcv_adr,
    output logic [DW-1:0] irtcv_wdat,
    input  logic [DW-1:0] irtcv_rdat,
    output logic          irtcv_exe,
    output logic          irtcv_learn,
    input  logic          irtcv_busy,
    input  logic          irtcv_drdy,
    input  logic          irtcv_err
);
    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_EXE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_BUS, S_RDWAIT, S_RSP, S_EXE_START, S_EXE_WAIT, S_LRN_WAIT
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [TO_W-1:0] r_cnt;
    logic            r_err_seen;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;
    logic            r_cs;
    logic            r_we;
    logic            r_den;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_wdat;
    logic            r_exe;
    logic            r_learn;
    logic            w_to;

    // Timeout fires one count before saturation so each wait phase lasts exactly TO_MAX cycles.
    assign w_to = (TO_MAX != '0) && (r_cnt == TO_MAX - 1'b1);

    always_ff @(posedge irtcv_clk or negedge irtcv_rst_async_n) begin
        if (!irtcv_rst_async_n) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_cnt       <= '0;
            r_err_seen  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_den       <= 1'b0;
            r_adr       <= '0;
            r_wdat      <= '0;
            r_exe       <= 1'b0;
            r_learn     <= 1'b0;
        end else begin
            if (r_cnt != TO_MAX) r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_cnt       <= '0;
                        if (cmd_op == OP_WR || cmd_op == OP_RD) begin
                            r_cs    <= 1'b1;
                            r_den   <= 1'b1;
                            r_we    <= (cmd_op == OP_WR);
                            r_adr   <= cmd_adr;
                            r_wdat  <= cmd_wdat;
                            r_state <= S_BUS;
                        end else if (cmd_op == OP_EXE) begin
                            r_exe   <= 1'b1;
                            r_state <= S_EXE_START;
                        end else begin
                            r_learn <= 1'b1;
                            r_state <= S_LRN_WAIT;
                        end
                    end
                end
                S_BUS: begin
                    r_cs  <= 1'b0;
                    r_den <= 1'b0;
                    r_we  <= 1'b0;
                    r_cnt <= '0;
                    if (r_op == OP_WR) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RSP;
                    end else begin
                        r_state <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= irtcv_rdat;
                    r_rsp_err   <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_RSP;
                end
                S_EXE_START: begin
                    if (irtcv_busy) begin
                        r_exe      <= 1'b0;
                        r_err_seen <= irtcv_err;
                        r_cnt      <= '0;
                        r_state    <= S_EXE_WAIT;
                    end else if (w_to) begin
                        r_exe       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_RSP;
                    end
                end
                S_EXE_WAIT: begin
                    if (!irtcv_busy) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= r_err_seen | irtcv_err;
                        r_cnt       <= '0;
                        r_state     <= S_RSP;
                    end else if (w_to) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_RSP;
                    end else begin
                        r_err_seen <= r_err_seen | irtcv_err;
                    end
                end
                S_LRN_WAIT: begin
                    // drdy wins over a coincident err: the learned data is still fetched.
                    if (irtcv_drdy) begin
                        r_learn <= 1'b0;
                        r_cs    <= 1'b1;
                        r_den   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= DR_ADR;
                        r_cnt   <= '0;
                        r_state <= S_BUS;
                    end else if (irtcv_err || w_to) begin
                        r_learn     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign irtcv_cs    = r_cs;
    assign irtcv_we    = r_we;
    assign irtcv_den   = r_den;
    assign irtcv_adr   = r_adr;
    assign irtcv_wdat  = r_wdat;
    assign irtcv_exe   = r_exe;
    assign irtcv_learn = r_learn;

endmodule

// File: tb/tb_irtcv_host.sv
// Bench for irtcv_host: a register-file/transceiver model answers the bus while a
// reference model predicts each response from the command and the stimulus scenario.
module tb_irtcv_host;
    localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_EXE = 2'b10, OP_LRN = 2'b11;
    localparam logic [3:0] DR = 4'h3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_adr = 4'h0;
    logic [7:0] cmd_wdat = 8'h00;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [7:0] rsp_data;
    logic       cs, we, den, exe, learn;
    logic [3:0] adr;
    logic [7:0] wdat, rdat;
    logic       busy = 1'b0, drdy = 1'b0, err = 1'b0;

    irtcv_host dut (
        .irtcv_clk(clk), .irtcv_rst_async_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_adr(cmd_adr), .cmd_wdat(cmd_wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .irtcv_cs(cs), .irtcv_we(we), .irtcv_den(den), .irtcv_adr(adr), .irtcv_wdat(wdat),
        .irtcv_rdat(rdat), .irtcv_exe(exe), .irtcv_learn(learn),
        .irtcv_busy(busy), .irtcv_drdy(drdy), .irtcv_err(err)
    );

    // Second instance with a short timeout; its transceiver never answers.
    logic       t_cmd_valid = 1'b0, t_cmd_ready, t_rsp_valid, t_rsp_ready = 1'b0, t_rsp_err;
    logic [1:0] t_cmd_op = 2'b00;
    logic [7:0] t_rsp_data, t_wdat;
    logic [3:0] t_adr;
    logic       t_cs, t_we, t_den, t_exe, t_learn;

    irtcv_host #(.TO_MAX(16'd8)) dut8 (
        .irtcv_clk(clk), .irtcv_rst_async_n(rst_n),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op),
        .cmd_adr(4'h0), .cmd_wdat(8'h00),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .irtcv_cs(t_cs), .irtcv_we(t_we), .irtcv_den(t_den), .irtcv_adr(t_adr), .irtcv_wdat(t_wdat),
        .irtcv_rdat(8'h00), .irtcv_exe(t_exe), .irtcv_learn(t_learn),
        .irtcv_busy(1'b0), .irtcv_drdy(1'b0), .irtcv_err(1'b0)
    );

    // Transceiver register file; address DR is the read-only learned-data register.
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] learn_val = 8'h00;
    always @(posedge clk) begin
        if (cs && den && we && adr != DR) mem[adr] <= wdat;
        if (cs && den && !we) rdat <= (adr == DR) ? learn_val : mem[adr];
        else                  rdat <= 8'($urandom);
    end

    logic [7:0] exp_mem [16] = '{default: 8'h00};
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                           input int bdly, input int blen, input logic errd, input logic errf,
                           input int ddly, input logic eonly, input logic both,
                           input logic [7:0] lval, input int stall);
        int n, acc, t0, exe_cnt, lrn_cnt, cs_cnt, first_rsp;
        logic got, cs_we, cs_den;
        logic [3:0] cs_adr;
        logic [7:0] cs_wdat, exp_d;
        logic exp_e;
        exp_d = 8'h00; exp_e = 1'b0;
        case (op)
            OP_WR:  if (a != DR) exp_mem[a] = d;
            OP_RD:  exp_d = (a == DR) ? learn_val : exp_mem[a];
            OP_EXE: exp_e = errd | errf;
            default: begin
                learn_val = lval;
                if (eonly) exp_e = 1'b1; else exp_d = lval;
            end
        endcase
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_adr = a; cmd_wdat = d; acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_adr = 4'($urandom); cmd_wdat = 8'($urandom);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        t0 = -1; exe_cnt = 0; lrn_cnt = 0; cs_cnt = 0; first_rsp = 0; got = 1'b0;
        cs_we = 1'b0; cs_den = 1'b0; cs_adr = 4'h0; cs_wdat = 8'h00;
        for (int k = 0; k < 300 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (cs) begin cs_cnt++; cs_we = we; cs_den = den; cs_adr = adr; cs_wdat = wdat; end
            if (exe) exe_cnt++;
            if (learn) lrn_cnt++;
            if (rsp_valid) begin
                got = 1'b1; first_rsp = cyc;
            end else if (op == OP_EXE) begin
                if (exe && t0 < 0) t0 = k;
                busy = (t0 >= 0 && k >= t0 + bdly && k < t0 + bdly + blen);
                err = 1'b0;
                if (t0 >= 0 && k == t0 + bdly + 1) err = errd;
                if (t0 >= 0 && k == t0 + bdly + blen) err = errf;
            end else if (op == OP_LRN) begin
                if (learn && t0 < 0) t0 = k;
                drdy = 1'b0; err = 1'b0;
                if (t0 >= 0 && k == t0 + ddly) begin
                    if (eonly) err = 1'b1;
                    else begin drdy = 1'b1; err = both; end
                end
            end
        end
        busy = 1'b0; drdy = 1'b0; err = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            chk("rsp_data", 32'(rsp_data), 32'(exp_d));
            chk("rsp_err", 32'(rsp_err), 32'(exp_e));
            case (op)
                OP_WR: begin
                    chk("wr_latency", 32'(first_rsp - acc), 32'd2);
                    chk("wr_strobes", 32'(cs_cnt), 32'd1);
                    chk("wr_bus", 32'({cs_we, cs_den, cs_adr, cs_wdat}), 32'({2'b11, a, d}));
                end
                OP_RD: begin
                    chk("rd_latency", 32'(first_rsp - acc), 32'd3);
                    chk("rd_strobes", 32'(cs_cnt), 32'd1);
                    chk("rd_bus", 32'({cs_we, cs_den, cs_adr}), 32'({2'b01, a}));
                end
                OP_EXE: begin
                    chk("exe_high", 32'(exe_cnt), 32'(bdly + 1));
                    chk("exe_strobes", 32'(cs_cnt), 32'd0);
                end
                default: begin
                    chk("lrn_high", 32'(lrn_cnt), 32'(ddly + 1));
                    chk("lrn_strobes", 32'(cs_cnt), eonly ? 32'd0 : 32'd1);
                    if (!eonly) chk("lrn_bus", 32'({cs_we, cs_den, cs_adr}), 32'({2'b01, DR}));
                end
            endcase
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("rsp_hold", 32'({rsp_valid, rsp_err, rsp_data}), 32'({1'b1, exp_e, exp_d}));
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("rsp_drop", 32'(rsp_valid), 32'd0);
            chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
        end
    endtask

    task automatic t8_run(input logic [1:0] op);
        int n, act;
        logic got;
        @(negedge clk);
        n = 0;
        while (!t_cmd_ready && n < 50) begin @(negedge clk); n++; end
        t_cmd_valid = 1'b1; t_cmd_op = op;
        @(negedge clk);
        t_cmd_valid = 1'b0;
        act = 0; got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (t_exe || t_learn) act++;
            if (t_rsp_valid) got = 1'b1;
        end
        chk("to_seen", 32'(got), 32'd1);
        chk("to_active", 32'(act), 32'd8);
        chk("to_rsp", 32'({t_rsp_err, t_rsp_data}), 32'({1'b1, 8'h00}));
        chk("to_bus_idle", 32'({t_cs, t_we, t_den, t_adr, t_wdat}), 32'd0);
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        chk("to_drop", 32'({t_rsp_valid, t_cmd_ready}), 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({cmd_ready, rsp_valid, rsp_err, rsp_data, cs, we, den, exe, learn}), 32'd0);
        chk("reset_bus", 32'({adr, wdat}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Reset in the middle of an EXE with exe asserted.
        cmd_valid = 1'b1; cmd_op = OP_EXE;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_exe_high", 32'(exe), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({exe, cs, cmd_ready, rsp_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", 32'({cmd_ready, exe}), 32'b10);

        run_cmd(OP_WR, 4'h2, 8'hA5, 0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0);
        run_cmd(OP_WR, 4'h1, 8'h3C, 0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0);
        run_cmd(OP_RD, 4'h1, 8'h00, 0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 5);
        run_cmd(OP_EXE, 4'h0, 8'h00, 2, 10, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1);
        run_cmd(OP_EXE, 4'h0, 8'h00, 2, 10, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h00, 0);
        run_cmd(OP_EXE, 4'h0, 8'h00, 0, 4, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h00, 0);
        run_cmd(OP_LRN, 4'h0, 8'h00, 0, 2, 1'b0, 1'b0, 20, 1'b0, 1'b0, 8'h5A, 2);
        run_cmd(OP_LRN, 4'h0, 8'h00, 0, 2, 1'b0, 1'b0, 3, 1'b0, 1'b1, 8'hC3, 0);
        run_cmd(OP_LRN, 4'h0, 8'h00, 0, 2, 1'b0, 1'b0, 5, 1'b1, 1'b0, 8'h77, 0);
        t8_run(OP_EXE);
        t8_run(OP_LRN);

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 6), $urandom_range(2, 10),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 30), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
